// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit that owns the architectural
// HI/LO registers. It sits in EX beside the ALU. A timed op computes its
// result into shadow registers at the accept edge. The unit then holds busy
// for a fixed latency and commits the shadows to HI/LO in one step, so
// readers never see a partial result.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      issue request for op this cycle
//   op[3:0]    0 MULT 1 MULTU 2 DIV 3 DIVU 4 MADD 5 MADDU 6 MSUB 7 MSUBU
//              8 MTHI 9 MTLO, 10-15 no-op
//   src_a      rs operand / dividend / MTHI-MTLO data
//   src_b      rt operand / divisor
//   flush      exception request; squashes a start in the same cycle
//   busy       op in flight (state == RUN)
//   remaining  busy cycles left, 0 when idle
//   done       one-cycle pulse after a timed op commits
//   hi, lo     architectural HI/LO
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic [7:0]       remaining,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [7:0]       count;
  logic [WIDTH-1:0] p_hi, p_lo;

  logic             commit, ready, accept, take_timed, take_move, sgn;
  logic [W2-1:0]    base, prod, quot, result;
  logic [7:0]       cycles;

  // Full 2*WIDTH product; operands are widened explicitly so one unsigned
  // multiplier serves both signed and unsigned ops (mod 2^(2*WIDTH)).
  function automatic logic [W2-1:0] mul_full(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             is_signed);
    logic [W2-1:0] ea, eb;
    ea = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes and
  // restores signs: quotient truncates toward zero, remainder follows the
  // dividend. Divide-by-zero and MIN/-1 have fixed results.
  function automatic logic [W2-1:0] div_full(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             is_signed);
    logic [WIDTH-1:0] min_val, mag_a, mag_b, q_mag, r_mag, q, r;
    logic             neg_a, neg_b;
    logic [W2-1:0]    res;
    min_val = {1'b1, {(WIDTH-1){1'b0}}};
    neg_a   = is_signed & a[WIDTH-1];
    neg_b   = is_signed & b[WIDTH-1];
    mag_a   = neg_a ? -a : a;
    mag_b   = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : (neg_b ? -b : b);
    q_mag   = mag_a / mag_b;
    r_mag   = mag_a % mag_b;
    q       = (neg_a ^ neg_b) ? -q_mag : q_mag;
    r       = neg_a ? -r_mag : r_mag;
    if (b == '0)
      res = {a, {WIDTH{1'b1}}};
    else if (is_signed && a == min_val && b == '1)
      res = {{WIDTH{1'b0}}, min_val};
    else
      res = {r, q};
    return res;
  endfunction

  always_comb begin
    commit = (state == RUN) && (count == 8'd1);
    // Issue is allowed on the commit edge too, so back-to-back ops keep busy
    // high; an accumulate issued then must see the value being committed.
    ready  = (state == IDLE) || commit;
    base   = commit ? {p_hi, p_lo} : {hi, lo};
    sgn    = ~op[0];
    prod   = mul_full(src_a, src_b, sgn);
    quot   = div_full(src_a, src_b, sgn);
    result = '0;
    cycles = MULT_N;
    case (op)
      4'd0, 4'd1: result = prod;
      4'd2, 4'd3: begin
        result = quot;
        cycles = DIV_N;
      end
      4'd4, 4'd5: result = base + prod;
      4'd6, 4'd7: result = base - prod;
      default:    result = '0;
    endcase
    accept     = start & ~flush;
    take_timed = accept & ready & (op <= 4'd7);
    take_move  = accept & (state == IDLE) & ((op == 4'd8) | (op == 4'd9));
  end

  assign busy      = (state == RUN);
  assign remaining = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else begin
      done <= 1'b0;
      // Commit stage: shadows land in HI/LO as the counter reaches zero.
      if (state == RUN) begin
        count <= count - 8'd1;
        if (commit) begin
          hi    <= p_hi;
          lo    <= p_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
      end
      // Accept stage: capture the full result and start the countdown.
      if (take_timed) begin
        state <= RUN;
        count <= cycles;
        p_hi  <= result[W2-1:WIDTH];
        p_lo  <= result[WIDTH-1:0];
      end
      if (take_move) begin
        if (op == 4'd8)
          hi <= src_a;
        else
          lo <= src_a;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [7:0]  remaining;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .busy(busy), .remaining(remaining),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int          n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
    longint      sa, sb;
    logic [63:0] sp, up, r;
    int          ia, ib, q, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sp = 64'(sa * sb);
    up = {32'b0, a} * {32'b0, b};
    r  = '0;
    case (o)
      4'd0: r = sp;
      4'd1: r = up;
      4'd4: r = acc + sp;
      4'd5: r = acc + up;
      4'd6: r = acc - sp;
      4'd7: r = acc - up;
      4'd2: begin
        ia = $signed(a);
        ib = $signed(b);
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          q  = ia / ib;
          rm = ia % ib;
          r  = {32'(rm), 32'(q)};
        end
      end
      4'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = acc;
    endcase
    return r;
  endfunction

  function automatic int cycles_of(input logic [3:0] o);
    return (o == 4'd2 || o == 4'd3) ? DC : MC;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from idle. Timed ops go to the scoreboard; untimed ones
  // (moves, no-ops, flushed starts) are checked one cycle later.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit fl);
    logic [63:0] e;
    bit timed, acc;
    timed = (o <= 4'd7);
    acc   = !fl && (o <= 4'd9);
    e     = '0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; flush = fl;
    if (acc && timed) e = ref_op(o, a, b, {m_hi, m_lo});
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    if (acc && timed) begin
      sb_q.push_back('{hi: e[63:32], lo: e[31:0], due: cyc + cycles_of(o)});
      {m_hi, m_lo} = e;
    end else begin
      if (acc && o == 4'd8) m_hi = a;
      if (acc && o == 4'd9) m_lo = a;
      @(negedge clk);
      chk("idle_after_untimed", 64'(busy), 64'(0));
      chk("hilo_after_untimed", {hi, lo}, {m_hi, m_lo});
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_idle: busy=%0b required 0 within 300 cycles", busy);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("commit_hi", 64'(hi), 64'(e.hi));
        chk("commit_lo", 64'(lo), 64'(e.lo));
        chk("commit_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_remaining", 64'(remaining), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hilo", {hi, lo}, 64'(0));

    // MULT -2*3 with cycle-by-cycle busy/remaining and HI/LO hold
    issue(4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    for (int k = 0; k < MC; k++) begin
      @(negedge clk);
      chk("mult_busy", 64'(busy), 64'(1));
      chk("mult_remaining", 64'(remaining), 64'(MC - k));
      chk("mult_hilo_hold", {hi, lo}, 64'(0));
    end
    @(negedge clk);
    chk("mult_busy_end", 64'(busy), 64'(0));
    chk("mult_done", 64'(done), 64'(1));
    chk("mult_result", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    @(negedge clk);
    chk("mult_done_once", 64'(done), 64'(0));

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0); wait_idle();
    chk("multu_result", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});

    issue(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0); wait_idle();
    chk("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(4'd2, 32'd5, 32'd0, 1'b0); wait_idle();
    chk("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    issue(4'd3, 32'd5, 32'd0, 1'b0); wait_idle();
    chk("divu_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
    chk("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});

    // Moves and accumulate
    issue(4'd8, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi", 64'(hi), 64'(32'h1234_5678));
    issue(4'd9, 32'h9ABC_DEF0, 32'd0, 1'b0);
    chk("mtlo", 64'(lo), 64'(32'h9ABC_DEF0));
    issue(4'd5, 32'h0001_0000, 32'h0001_0000, 1'b0); wait_idle();
    chk("maddu", {hi, lo}, {32'h1234_5679, 32'h9ABC_DEF0});
    issue(4'd6, 32'd1, 32'd1, 1'b0); wait_idle();
    chk("msub", {hi, lo}, {32'h1234_5679, 32'h9ABC_DEEF});

    // Start squashed by flush; flush during RUN does not abort
    issue(4'd0, 32'd7, 32'd9, 1'b1);
    issue(4'd2, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_idle();
    chk("div_under_flush", {hi, lo}, {32'd2, 32'd14});

    // Start while busy is dropped
    issue(4'd0, 32'd6, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 4'd3; src_a = 32'd100; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    chk("dropped_busy", 64'(busy), 64'(0));
    chk("dropped_result", {hi, lo}, {32'd0, 32'd42});

    // Back-to-back: start held on the commit edge
    issue(4'd1, 32'd3, 32'd4, 1'b0);
    repeat (MC) @(negedge clk);
    chk("b2b_last_cycle", 64'(remaining), 64'(1));
    start = 1'b1; op = 4'd4; src_a = 32'd2; src_b = 32'd5;
    e = ref_op(4'd4, 32'd2, 32'd5, {m_hi, m_lo});
    @(posedge clk);
    #1 start = 1'b0;
    sb_q.push_back('{hi: e[63:32], lo: e[31:0], due: cyc + MC});
    {m_hi, m_lo} = e;
    @(negedge clk);
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_remaining", 64'(remaining), 64'(MC));
    wait_idle();
    chk("b2b_result", {hi, lo}, {32'd0, 32'd22});

    // Reset in the 2nd RUN cycle discards the pending result
    issue(4'd0, 32'd3, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("midrun_reset_busy", 64'(busy), 64'(0));
    chk("midrun_reset_hilo", {hi, lo}, 64'(0));
    chk("midrun_reset_remaining", 64'(remaining), 64'(0));
    repeat (10) @(negedge clk);

    // Randomised ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [3:0] o;
      bit fl;
      o  = 4'($urandom_range(0, 15));
      fl = ($urandom_range(0, 7) == 0);
      issue(o, pick(), pick(), fl);
      if (o <= 4'd7 && !fl) wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
